// File: rtl/alu_issue_buffer.sv
// In-order operation queue feeding a registered single-cycle ALU; lookahead issue of the
// entry behind the head lets back-to-back results leave on consecutive cycles.
module alu_issue_buffer #(
   parameter int DEPTH = 4,
   parameter int TAG_W = 4
) (
   input  logic                   clk,
   input  logic                   clear_n,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [3:0]             in_op,
   input  logic [31:0]            in_a,
   input  logic [31:0]            in_b,
   input  logic [TAG_W-1:0]       in_tag,
   output logic [31:0]            alu_in0,
   output logic [31:0]            alu_in1,
   output logic [3:0]             control_signal,
   input  logic [31:0]            alu_out,
   input  logic                   zero_flag,
   output logic                   res_valid,
   input  logic                   res_ready,
   output logic [31:0]            res_data,
   output logic                   res_zero,
   output logic [TAG_W-1:0]       res_tag,
   output logic [$clog2(DEPTH):0] occupancy
);
   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

   logic [3:0]       op_q  [DEPTH];
   logic [31:0]      a_q   [DEPTH];
   logic [31:0]      b_q   [DEPTH];
   logic [TAG_W-1:0] tag_q [DEPTH];

   logic [PTR_W-1:0] head, tail, head_nxt, sel;
   logic [CNT_W-1:0] count;
   logic             busy, push, pop, lookahead;

   assign push      = in_valid && in_ready;
   assign pop       = busy && res_ready;
   assign in_ready  = (count != FULL);
   assign head_nxt  = head + PTR_W'(1);
   // When the head result leaves this edge, the ALU must already be fed the next entry.
   assign lookahead = busy && res_ready && (count >= CNT_W'(2));
   assign sel       = lookahead ? head_nxt : head;

   always_comb begin
      alu_in0        = '0;
      alu_in1        = '0;
      control_signal = 4'b1111;
      if (count != '0) begin
         alu_in0        = a_q[sel];
         alu_in1        = b_q[sel];
         control_signal = op_q[sel];
      end
   end

   always_ff @(posedge clk or negedge clear_n) begin
      if (!clear_n) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
         busy  <= 1'b0;
      end else begin
         if (push) tail <= tail + PTR_W'(1);
         if (pop)  head <= head_nxt;
         case ({push, pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
         if (!busy)    busy <= (count != '0);
         else if (pop) busy <= (count >= CNT_W'(2));
      end
   end

   // Payload storage carries no reset; occupancy alone says which slots are live.
   always_ff @(posedge clk) begin
      if (push) begin
         op_q[tail]  <= in_op;
         a_q[tail]   <= in_a;
         b_q[tail]   <= in_b;
         tag_q[tail] <= in_tag;
      end
   end

   assign res_valid = busy;
   assign res_data  = alu_out;
   assign res_zero  = zero_flag;
   assign res_tag   = tag_q[head];
   assign occupancy = count;

endmodule

// File: doc/alu_issue_buffer.md
ALU_ISSUE_BUFFER -- requirements
Module: alu_issue_buffer

Interface
REQ-001 The block SHALL have parameter DEPTH, default 4, meaning the operation queue depth in entries (power of two, at least 2).
REQ-002 The block SHALL have parameter TAG_W, default 4, meaning the width of the caller-supplied operation tag.
REQ-003 One clock; reset is asynchronous and active-low.
REQ-004 Port clk, input, 1 bit: rising-edge clock, shared with the downstream ALU.
REQ-005 Port clear_n, input, 1 bit: asynchronous active-low reset.
REQ-006 Ports in_valid (input, 1) and in_ready (output, 1): request handshake.
REQ-007 Ports in_op (input, 4), in_a (input, 32), in_b (input, 32) and in_tag (input, TAG_W): opcode, operand A, operand B and tag of the request.
REQ-008 Ports alu_in0 (output, 32), alu_in1 (output, 32) and control_signal (output, 4): operands and opcode driven to the ALU.
REQ-009 Ports alu_out (input, 32) and zero_flag (input, 1): registered ALU result and its zero flag.
REQ-010 Ports res_valid (output, 1) and res_ready (input, 1): result handshake.
REQ-011 Ports res_data (output, 32), res_zero (output, 1) and res_tag (output, TAG_W): result, zero flag and tag.
REQ-012 Port occupancy, output, clog2(DEPTH)+1 bits: number of queued entries, including the one in flight.

Function
REQ-013 A request SHALL be accepted on a rising edge where in_valid and in_ready are both 1.
- Accepted {op, a, b, tag} is written at the tail; tail advances and wraps modulo DEPTH.
REQ-014 in_ready SHALL equal (occupancy != DEPTH); there is no same-cycle pass-through when full.
REQ-015 The block SHALL use state busy (1 bit): busy=1 means the head entry has been captured by the ALU and its result is on alu_out.
REQ-016 ALU drive is combinational, selected by the first matching rule:
- if busy=1, res_ready=1 and occupancy>=2: drive entry head+1 (lookahead);
- else if occupancy>=1: drive the head entry;
- else: alu_in0=0, alu_in1=0, control_signal=4'b1111.
REQ-017 Issue latency SHALL be 1 cycle: the ALU captures the driven entry at edge N and the result appears at res_data after edge N.
REQ-018 Transitions of busy:
- 0 -> 1 at an edge where occupancy>=1;
- 1 -> 1 at a pop edge where occupancy>=2 (lookahead issue, no bubble);
- 1 -> 0 at a pop edge where occupancy==1;
- 1 -> 1 with head unchanged when res_ready=0.
REQ-019 While busy=1 and res_ready=0, the head entry SHALL be re-driven every cycle so that alu_out and zero_flag stay stable.
REQ-020 res_valid SHALL equal busy; res_data=alu_out; res_zero=zero_flag; res_tag=tag of the head entry.
REQ-021 A pop SHALL occur on an edge where res_valid and res_ready are both 1; head advances and wraps modulo DEPTH.
REQ-022 A simultaneous push and pop SHALL leave occupancy unchanged and both pointers advanced.
REQ-023 Sustained throughput SHALL be one result per cycle when in_valid=1 and res_ready=1 continuously.
REQ-024 Opcodes 4'b1010-4'b1111 SHALL be queued and issued unchanged; the ALU returns 0, so res_zero=1.
REQ-025 Results SHALL return in acceptance order; the tag is never modified.

Reset
REQ-026 While clear_n=0, asynchronously:
- head=0, tail=0, occupancy=0, busy=0;
- res_valid=0, in_ready=1;
- ALU drive at the idle values of REQ-016.
REQ-027 Reset mid-operation SHALL discard all queued and in-flight entries with no result delivered.
REQ-028 The first accept SHALL be possible on the first edge after clear_n rises; the ALU's own reset is controlled at top level.

Verification
REQ-029 After reset, push {ADD, 5, 7, tag 3} with res_ready=1 -> res_valid=1 one cycle later, res_data=12, res_zero=0, res_tag=3.
REQ-030 Push SUB 9-9, AND, OR, XOR back-to-back with res_ready=1 -> four results on consecutive cycles, first is 0 with res_zero=1, no bubbles.
REQ-031 Hold res_ready=0 and push 5 ops -> in_ready=0 after the 4th, occupancy=4, res_data constant at the first result.
REQ-032 Raise res_ready -> results drain in order; occupancy steps 4,3,2,1,0 and busy=0 after the last pop.
REQ-033 Push SLT with a=32'hFFFFFFFF, b=1 and opcode 4'b1100 -> results 1 then 0, the second with res_zero=1.
REQ-034 Assert clear_n=0 with 3 queued entries and busy=1 -> res_valid=0 and occupancy=0 immediately; no stale result after release.
